// File: rtl/reduce_unit_scheduler.sv
// Round-robin scheduler that time-shares one combinational 4-bit reduction unit among NUM_REQ requesters.
// Define REDUCE_SCHED_STATS_EN to add txn_count, an 8-bit saturating count of response handshakes.
module reduce_unit_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 4,
   parameter int ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         unit_in,
   input  logic                      unit_out_1,
   input  logic                      unit_out_2,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      rsp_out_1,
   output logic                      rsp_out_2,
   output logic                      busy
`ifdef REDUCE_SCHED_STATS_EN
   ,
   output logic [7:0]                txn_count
`endif
);

   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   last_grant_q, id_q, rsp_id_q;
   logic [ID_W-1:0]   grant_idx, scan_idx;
   logic              grant_found, accept;
   logic [DATA_W-1:0] op_q;
   logic              rsp_out_1_q, rsp_out_2_q;
   logic [DATA_W-1:0] req_ops [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_ops
      assign req_ops[k] = req_data[k*DATA_W +: DATA_W];
   end

   // Scan starts one past the last grant so the requester just served ranks last.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = last_grant_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = (scan_idx == ID_W'(NUM_REQ-1)) ? '0 : scan_idx + ID_W'(1);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grant_found && !reset) begin
               req_ready[grant_idx] = 1'b1;
               accept               = 1'b1;
               state_d              = EVAL;
            end
         end
         EVAL:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q         <= '0;
         id_q         <= '0;
         last_grant_q <= ID_W'(NUM_REQ-1);
         rsp_id_q     <= '0;
         rsp_out_1_q  <= 1'b0;
         rsp_out_2_q  <= 1'b0;
      end else begin
         if (accept) begin
            op_q         <= req_ops[grant_idx];
            id_q         <= grant_idx;
            last_grant_q <= grant_idx;
         end
         if (state_q == EVAL) begin
            rsp_out_1_q <= unit_out_1;
            rsp_out_2_q <= unit_out_2;
            rsp_id_q    <= id_q;
         end
      end
   end

   assign unit_in   = op_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_out_1 = rsp_out_1_q;
   assign rsp_out_2 = rsp_out_2_q;
   assign busy      = (state_q != IDLE);

`ifdef REDUCE_SCHED_STATS_EN
   logic [7:0] txn_count_q;
   logic       rsp_fire;

   assign rsp_fire = rsp_valid & rsp_ready;

   always_ff @(posedge clk) begin
      if (reset)                              txn_count_q <= '0;
      else if (rsp_fire && txn_count_q != 8'hFF) txn_count_q <= txn_count_q + 8'd1;
   end

   assign txn_count = txn_count_q;
`endif

endmodule

// File: doc/reduce_unit_scheduler.md
Name: reduce_unit_scheduler

Overview:
- Shares one combinational 4-bit reduction unit (in_1 -> out_1, out_2) among NUM_REQ requesters.
- Round-robin arbitration; each requester offers a 4-bit operand on a valid/ready handshake.
- The scheduler drives the shared unit, captures both result bits, and returns them with the requester ID on a valid/ready response channel.
- Sits between client blocks and the single reduction-unit instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 4, operand width; matches the shared unit's in_1 width
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_data  input  NUM_REQ*DATA_W  operands; requester k occupies bits [k*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant/accept; only ever asserted in IDLE
unit_in  output  DATA_W  operand to shared unit in_1
unit_out_1  input  1  shared unit out_1
unit_out_2  input  1  shared unit out_2
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  index of requester served
rsp_out_1  output  1  captured out_1
rsp_out_2  output  1  captured out_2
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values:
  - State IDLE.
  - unit_in, rsp_id, rsp_out_1, rsp_out_2, rsp_valid, busy = 0.
  - req_ready = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any req_valid bit is high, grant g = first valid index searching last_grant+1, +2, ... modulo NUM_REQ.
  - req_ready[g] = 1 combinationally in the same cycle; all other req_ready bits are 0.
  - Handshake completes that cycle. On the edge: op_reg <= req_data[g], id_reg <= g, last_grant <= g, state -> EVAL.
  - No valid requests: remain in IDLE; req_ready = 0.
- EVAL (1 cycle):
  - unit_in = op_reg. unit_in is a registered output; it is updated at the accept edge and holds between transactions.
  - On the edge: rsp_out_1 <= unit_out_1, rsp_out_2 <= unit_out_2, rsp_id <= id_reg, state -> RESP.
- RESP:
  - rsp_valid = 1. rsp_id, rsp_out_1 and rsp_out_2 stay stable until the handshake.
  - On rsp_valid & rsp_ready: state -> IDLE. rsp_valid is deasserted in the next cycle.
  - While in RESP, no req_ready is asserted.
- Latency and throughput:
  - Accept at cycle T -> rsp_valid high at T+2.
  - Response handshake at T+2 -> earliest next accept at T+3. Maximum throughput is 1 transaction per 3 cycles.
- Requester rules: a requester must hold req_valid and req_data stable until it sees req_ready. A valid dropped before grant is simply not served.
- Simultaneous requests: strict round robin. A requester that was just served has lowest priority in the next arbitration.
- Reset mid-operation (EVAL or RESP): the transaction is discarded, with no response. Everything returns to reset values on the next edge.
- No combinational path from rsp_ready to req_ready.

Optional Feature:
- Macro: REDUCE_SCHED_STATS_EN
- Defined:
  - Adds output port txn_count, 8 bits.
  - Increments by 1 on each response handshake (rsp_valid & rsp_ready).
  - Saturates at 255.
  - Cleared to 0 by reset.
- Undefined: port txn_count and its logic are absent; all other behaviour is identical.

Test Plan:
Bench model for the shared unit: unit_out_1 = &unit_in, unit_out_2 = |unit_in.
1. Reset: assert reset 2 cycles with random req_valid -> busy=0, rsp_valid=0, req_ready=0, unit_in=0 in every cycle reset is high.
2. Single request: req_valid[2]=1, data 4'b1101, rsp_ready=1 -> req_ready=4'b0100 for 1 cycle; unit_in=4'b1101 next cycle; rsp_valid at T+2 with rsp_id=2, rsp_out_1=0, rsp_out_2=1.
3. All valid at once, data {1111,1101,1010,0000} for requesters {3,2,1,0}, each valid held until its grant, rsp_ready=1 -> serve order 0,1,2,3 with grants 3 cycles apart. Responses: (0,0), (0,1), (0,1), (1,1).
4. Backpressure: hold rsp_ready=0 for 5 cycles with req_valid[1] pending -> rsp_valid stays 1 with a stable payload, req_ready stays 0. Release rsp_ready -> requester 1 is granted 1 cycle after the response handshake.
5. Fairness: req_valid[0] and req_valid[3] held high continuously -> grant sequence 0,3,0,3,... with no starvation over 20 transactions.
6. Reset during EVAL -> next cycle IDLE, rsp_valid never asserted for that transaction, next grant goes to requester 0. With REDUCE_SCHED_STATS_EN: txn_count returns to 0 after reset, and reads 255 after 300 transactions.
